// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: one memory op per cycle, wdata staged one op ahead,
// reads checked two cycles later with sticky first-failure capture.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int LAST_ADDR  = 71,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [ERR_W-1:0]      err_count
);

    localparam int STAGES = 2;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } cmp_t;

    state_t                state;
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  phase;
    logic                  last_op;
    logic                  drain_cnt;
    logic [STAGES:0]       vld_pipe;
    cmp_t [STAGES:0]       cmp_pipe;

    logic                  issue;
    logic                  is_down;
    logic                  op_wr;
    logic                  op_last;
    logic                  elem_end;
    logic [DATA_WIDTH-1:0] op_exp;
    logic [2:0]            nxt_elem;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic                  nxt_phase;
    logic [DATA_WIDTH-1:0] nxt_wdata;

    // E1..E4 are read-then-write pairs; E0 is write-only, E5 read-only.
    function automatic logic is_rw(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wr_val(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? ONES : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_val(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? ONES : '0;
    endfunction

    // elem/addr/phase name the op to issue next; the nxt_* values name the one after it.
    always_comb begin
        is_down   = (elem == 3'd3) || (elem == 3'd4);
        op_wr     = (elem == 3'd0) || (is_rw(elem) && phase);
        op_exp    = rd_val(elem);
        op_last   = (elem == 3'd5) && (addr == LAST);
        elem_end  = is_down ? (addr == '0) : (addr == LAST);
        nxt_elem  = elem;
        nxt_addr  = addr;
        nxt_phase = 1'b0;
        if (is_rw(elem) && !phase) begin
            nxt_phase = 1'b1;
        end else if (elem_end) begin
            nxt_elem = elem + 3'd1;
            nxt_addr = ((elem == 3'd2) || (elem == 3'd3)) ? LAST : '0;
        end else begin
            nxt_addr = is_down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
        nxt_wdata = wr_val(nxt_elem);
        issue     = ((state == RUN) && !last_op) ||
                    (((state == IDLE) || (state == DONE)) && start);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            write_read <= 1'b0;
            address    <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            err_count  <= '0;
            elem       <= '0;
            addr       <= '0;
            phase      <= 1'b0;
            last_op    <= 1'b0;
            drain_cnt  <= 1'b0;
            vld_pipe   <= '0;
            cmp_pipe   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
            for (int i = STAGES; i > 0; i--) cmp_pipe[i] <= cmp_pipe[i-1];

            if (vld_pipe[STAGES] && (rdata != cmp_pipe[STAGES].exp)) begin
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= cmp_pipe[STAGES].addr;
                    fail_elem <= cmp_pipe[STAGES].elem;
                end
            end

            // Start clearing sits after the compare so it wins on the same edge.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        err_count <= '0;
                    end
                end
                RUN: begin
                    if (last_op) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                write_read  <= op_wr;
                address     <= addr;
                wdata       <= nxt_wdata;
                elem        <= nxt_elem;
                addr        <= nxt_addr;
                phase       <= nxt_phase;
                last_op     <= op_last;
                vld_pipe[0] <= !op_wr;
                cmp_pipe[0] <= '{exp: op_exp, addr: addr, elem: elem};
            end else begin
                // Parked on E0 w0 @0 so the next start issues immediately with wdata=0.
                write_read <= 1'b0;
                address    <= '0;
                wdata      <= '0;
                elem       <= '0;
                addr       <= '0;
                phase      <= 1'b0;
                last_op    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty behavioural memory plus a table-driven March C- model.
module tb_mbist_march_ctrl;

    localparam int DW     = 8;
    localparam int AW     = 7;
    localparam int LAST   = 71;
    localparam int EW     = 8;
    localparam int NOPS   = 10 * (LAST + 1);
    localparam int T_DONE = NOPS + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          write_read;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LAST), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_elem(fail_elem), .err_count(err_count)
    );

    int checks = 0;
    int failures = 0;
    int t = 0;
    bit armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
        end
    endtask

    // Expected op stream, straight from the element table.
    bit        op_wr   [NOPS];
    int        op_addr [NOPS];
    int        op_elem [NOPS];
    logic [7:0] op_data [NOPS];
    int        nops = 0;

    function automatic void push_op(input bit w, input int a, input logic [7:0] d, input int e);
        op_wr[nops] = w; op_addr[nops] = a; op_data[nops] = d; op_elem[nops] = e;
        nops++;
    endfunction

    function automatic void build_ops();
        int a;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i <= LAST; i++) begin
                a = (e == 3 || e == 4) ? LAST - i : i;
                if (e == 0) push_op(1'b1, a, 8'h00, e);
                else if (e == 5) push_op(1'b0, a, 8'h00, e);
                else begin
                    push_op(1'b0, a, (e == 2 || e == 4) ? 8'hFF : 8'h00, e);
                    push_op(1'b1, a, (e == 1 || e == 3) ? 8'hFF : 8'h00, e);
                end
            end
        end
    endfunction

    // Fault configuration: 0 none, 1 stuck-at on one bit of one word, 2 rdata forced to 0x5A.
    int f_mode = 0;
    int f_addr = 0;
    int f_bit  = 0;
    bit f_val  = 1'b0;

    function automatic logic [7:0] mem_view(input logic [7:0] v, input int a);
        logic [7:0] r;
        r = v;
        if (f_mode == 1 && a == f_addr) r[f_bit] = f_val;
        if (f_mode == 2) r = 8'h5A;
        return r;
    endfunction

    function automatic void ref_final(output int rf, output int ra, output int re, output int rc);
        logic [7:0] m [0:LAST];
        rf = 0; ra = 0; re = 0; rc = 0;
        for (int i = 0; i < nops; i++) begin
            if (op_wr[i]) m[op_addr[i]] = op_data[i];
            else if (mem_view(m[op_addr[i]], op_addr[i]) != op_data[i]) begin
                if (rc < 255) rc++;
                if (rf == 0) begin rf = 1; ra = op_addr[i]; re = op_elem[i]; end
            end
        end
    endfunction

    // Memory under test: write commits previous-cycle wdata, read data lands two cycles later.
    logic [DW-1:0] mem [0:127];
    logic [DW-1:0] wd_q = '0;
    logic [DW-1:0] rd1 = '0;
    logic [DW-1:0] rd2 = '0;

    initial for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

    always @(negedge clk) begin
        rdata = rd2;
        rd2   = rd1;
        rd1   = mem_view(mem[address], int'(address));
        if (write_read) mem[address] = wd_q;
        wd_q  = wdata;
    end

    // Model timeline: t counts cycles since an accepted start (0 = idle after reset).
    int pf, pa, pe, pc;
    int ef = 0, ea = 0, ee = 0, ec = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1'b1; t = 0; ef = 0; ea = 0; ee = 0; ec = 0;
        end else if (start && (t == 0 || t >= T_DONE)) begin
            t = 1;
            ref_final(pf, pa, pe, pc);
            ef = 0; ea = 0; ee = 0; ec = 0;
        end else if (t > 0) begin
            t++;
            if (t == T_DONE) begin ef = pf; ea = pa; ee = pe; ec = pc; end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (t == 0 || t >= T_DONE) begin
                chk("idle_write_read", write_read, 0);
                chk("idle_address", address, 0);
                chk("idle_wdata", wdata, 0);
                chk("idle_busy", busy, 0);
                chk("done", done, (t >= T_DONE) ? 1 : 0);
            end else if (t <= NOPS) begin
                chk("op_write_read", write_read, op_wr[t-1]);
                chk("op_address", address, op_addr[t-1]);
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                if (t < NOPS && op_wr[t]) chk("staged_wdata", wdata, op_data[t]);
            end else begin
                chk("drain_write_read", write_read, 0);
                chk("drain_address", address, 0);
                chk("drain_busy", busy, 1);
                chk("drain_done", done, 0);
            end
            if (t <= 2 || t >= T_DONE) begin
                chk("fail", fail, ef);
                chk("fail_addr", fail_addr, ea);
                chk("fail_elem", fail_elem, ee);
                chk("err_count", err_count, ec);
            end
        end
    end

    task automatic run_test(input int ign_at, input int abort_at, output int nbusy);
        int c;
        nbusy = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 1;
        while (c < 1000 && !done) begin
            if (busy) nbusy++;
            start = (c == ign_at);
            if (c == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("done_reached", done, 1);
    endtask

    task automatic directed(input string nm, input int mode, input int a, input int b, input bit v,
                            input int xf, input int xa, input int xe, input int xc, input int ign);
        int nb, mf, ma, me, mc;
        f_mode = mode; f_addr = a; f_bit = b; f_val = v;
        ref_final(mf, ma, me, mc);
        chk({nm, "_model_fail"}, mf, xf);
        chk({nm, "_model_addr"}, ma, xa);
        chk({nm, "_model_elem"}, me, xe);
        chk({nm, "_model_errs"}, mc, xc);
        run_test(ign, 0, nb);
        chk({nm, "_busy_cycles"}, nb, 722);
        chk({nm, "_fail"}, fail, xf);
        chk({nm, "_fail_addr"}, fail_addr, xa);
        chk({nm, "_fail_elem"}, fail_elem, xe);
        chk({nm, "_err_count"}, err_count, xc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, ign, ab;
        build_ops();
        chk("model_nops", nops, 720);
        chk("model_op0", {op_wr[0], 8'(op_addr[0])}, {1'b1, 8'd0});
        chk("model_op359", {op_wr[359], 8'(op_addr[359])}, {1'b1, 8'd71});
        chk("model_op360", {op_wr[360], 8'(op_addr[360])}, {1'b0, 8'd71});
        chk("model_op648_elem", op_elem[648], 5);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        directed("clean", 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        directed("sa1_a5_b2", 1, 5, 2, 1'b1, 1, 5, 1, 3, 0);
        directed("sa0_a71_b7", 1, 71, 7, 1'b0, 1, 71, 2, 2, 0);
        directed("force_5a", 2, 0, 0, 1'b0, 1, 0, 1, 255, 0);

        // Reset during op 300, then a clean rerun.
        f_mode = 0;
        run_test(0, 301, nb);
        chk("abort_write_read", write_read, 0);
        chk("abort_busy", busy, 0);
        chk("abort_flags", {fail, err_count}, 0);
        directed("after_abort", 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);

        // Start ignored at op 100, then restart straight out of DONE.
        directed("ign_start", 1, 5, 2, 1'b1, 1, 5, 1, 3, 101);
        directed("restart", 1, 5, 2, 1'b1, 1, 5, 1, 3, 0);

        for (int r = 0; r < 8; r++) begin
            f_mode = int'($urandom_range(0, 3));
            if (f_mode == 3) f_mode = 1;
            f_addr = int'($urandom_range(0, LAST));
            f_bit  = int'($urandom_range(0, 7));
            f_val  = 1'($urandom_range(0, 1));
            ign = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 722)) : 0;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 720)) : 0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_test(ign, ab, nb);
            if (ab == 0) chk("rand_busy_cycles", nb, 722);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
